// File: rtl/dma_multi_channel_if.sv
// Memory-side bus of the DMA engine: one valid/ready transaction port.
// The engine drives the request side (master); the memory arbiter answers (slave).
interface dma_multi_channel_if #(
    parameter int ADDR_W = 32
);
    logic              bus_req;
    logic [ADDR_W-1:0] bus_addr;
    logic              bus_wen;
    logic [1:0]        bus_size;
    logic [31:0]       bus_wdata;
    logic [31:0]       bus_rdata;
    logic              bus_ready;

    modport master (
        output bus_req, bus_addr, bus_wen, bus_size, bus_wdata,
        input  bus_rdata, bus_ready
    );

    modport slave (
        input  bus_req, bus_addr, bus_wen, bus_size, bus_wdata,
        output bus_rdata, bus_ready
    );
endinterface

// File: rtl/dma_multi_channel.sv
// Multi-channel DMA engine. Fixed-priority arbitration (channel 0 highest),
// preemption only between READ+WRITE units, one shared memory bus port.
// All outputs are registered and computed from next-state values.
module dma_multi_channel #(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_b,
    input  logic [NUM_CH*ADDR_W-1:0] ch_sad,
    input  logic [NUM_CH*ADDR_W-1:0] ch_dad,
    input  logic [NUM_CH*CNT_W-1:0]  ch_cnt,
    input  logic [NUM_CH*10-1:0]     ch_ctl,
    input  logic [NUM_CH-1:0]        ch_trig,
    dma_multi_channel_if.master      bus,
    output logic                     busy,
    output logic [NUM_CH-1:0]        irq,
    output logic [NUM_CH-1:0]        ch_disable
);
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    // Packed views of the flat per-channel config buses.
    logic [NUM_CH-1:0][ADDR_W-1:0] cfg_sad, cfg_dad;
    logic [NUM_CH-1:0][CNT_W-1:0]  cfg_cnt;
    logic [NUM_CH-1:0][9:0]        ctl;
    logic [NUM_CH-1:0]             ch_en;

    assign cfg_sad = ch_sad;
    assign cfg_dad = ch_dad;
    assign cfg_cnt = ch_cnt;
    assign ctl     = ch_ctl;

    // Enable bit of every channel, gathered for edge detection.
    always_comb begin
        ch_en = '0;
        for (int i = 0; i < NUM_CH; i++) ch_en[i] = ctl[i][0];
    end

    // Per-channel shadow state.
    logic [NUM_CH-1:0][ADDR_W-1:0] sad_q, sad_d, dad_q, dad_d;
    logic [NUM_CH-1:0][CNT_W-1:0]  cnt_q, cnt_d;
    logic [NUM_CH-1:0]             en_prev_q, en_prev_d;
    logic [NUM_CH-1:0]             armed_q, armed_d;
    logic [NUM_CH-1:0]             pend_q, pend_d;
    logic [NUM_CH-1:0]             drop_q, drop_d;   // enable fell while active
    logic [NUM_CH-1:0]             word_q, word_d;   // unit size latched at arming

    // Engine state.
    state_t        state_q, state_d;
    logic [CW-1:0] cur_q, cur_d;
    logic [31:0]   data_q, data_d;

    // Registered outputs.
    logic              bus_req_q, bus_req_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic              bus_wen_q, bus_wen_d;
    logic [1:0]        bus_size_q, bus_size_d;
    logic [31:0]       bus_wdata_q, bus_wdata_d;
    logic [NUM_CH-1:0] irq_q, irq_d;
    logic [NUM_CH-1:0] dis_q, dis_d;

    // Arbitration signals.
    logic [NUM_CH-1:0] elig;
    logic              gnt_vld;
    logic [CW-1:0]     gnt_idx;
    logic              preempt;

    function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] a,
                                                input logic w);
        logic [ADDR_W-1:0] r;
        r    = a;
        r[0] = 1'b0;
        if (w) r[1] = 1'b0;
        return r;
    endfunction

    // Mode 1 decrements, mode 2 holds, modes 0 and 3 increment.
    function automatic logic [ADDR_W-1:0] step(input logic [ADDR_W-1:0] a,
                                               input logic [1:0] mode,
                                               input logic w);
        logic [ADDR_W-1:0] inc, r;
        inc = w ? ADDR_W'(4) : ADDR_W'(2);
        case (mode)
            2'd1:    r = a - inc;
            2'd2:    r = a;
            default: r = a + inc;
        endcase
        return r;
    endfunction

    // Fixed priority: lowest-index pending channel whose enable is still high.
    always_comb begin
        elig    = pend_q & ch_en;
        gnt_vld = |elig;
        gnt_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (elig[i]) gnt_idx = CW'(i);
        preempt = 1'b0;
        for (int i = 0; i < NUM_CH; i++)
            if (elig[i] && (i < int'(cur_q))) preempt = 1'b1;
    end

    // Next-state logic: channel arming/triggers first, then the transfer FSM,
    // whose decisions for the active channel take precedence.
    always_comb begin
        logic             act;
        logic [CW-1:0]    c;
        logic [CNT_W-1:0] rem;

        en_prev_d = ch_en;
        armed_d   = armed_q;
        pend_d    = pend_q;
        drop_d    = drop_q;
        word_d    = word_q;
        sad_d     = sad_q;
        dad_d     = dad_q;
        cnt_d     = cnt_q;
        state_d   = state_q;
        cur_d     = cur_q;
        data_d    = data_q;
        irq_d     = '0;
        dis_d     = '0;
        c         = cur_q;
        rem       = cnt_q[cur_q] - 1'b1;

        for (int i = 0; i < NUM_CH; i++) begin
            act = (state_q != IDLE) && (int'(cur_q) == i);
            if (ch_en[i] && !en_prev_q[i] && !act) begin
                armed_d[i] = 1'b1;
                word_d[i]  = ctl[i][3];
                sad_d[i]   = align(cfg_sad[i], ctl[i][3]);
                dad_d[i]   = align(cfg_dad[i], ctl[i][3]);
                cnt_d[i]   = cfg_cnt[i];
                pend_d[i]  = (ctl[i][9:8] == 2'd0);
                drop_d[i]  = 1'b0;
            end else if (!ch_en[i] && armed_q[i]) begin
                // An active unit must finish; otherwise disarm at once.
                if (act) begin
                    drop_d[i] = 1'b1;
                end else begin
                    armed_d[i] = 1'b0;
                    pend_d[i]  = 1'b0;
                end
            end else if (armed_q[i] && (ctl[i][9:8] != 2'd0) && ch_trig[i]) begin
                pend_d[i] = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    cur_d   = gnt_idx;
                    state_d = READ;
                end
            end
            READ: begin
                if (bus.bus_ready) begin
                    data_d  = bus.bus_rdata;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (bus.bus_ready) begin
                    sad_d[c] = step(sad_q[c], ctl[c][5:4], word_q[c]);
                    dad_d[c] = step(dad_q[c], ctl[c][7:6], word_q[c]);
                    cnt_d[c] = rem;
                    if (drop_q[c] || !ch_en[c]) begin
                        // Enable was withdrawn mid-unit: quiet disarm.
                        armed_d[c] = 1'b0;
                        pend_d[c]  = 1'b0;
                        drop_d[c]  = 1'b0;
                        state_d    = IDLE;
                    end else if (rem == '0) begin
                        irq_d[c] = ctl[c][2];
                        if (ctl[c][1] && (ctl[c][9:8] != 2'd0)) begin
                            cnt_d[c] = cfg_cnt[c];
                            if (ctl[c][7:6] == 2'd3)
                                dad_d[c] = align(cfg_dad[c], word_q[c]);
                            pend_d[c] = 1'b0;
                        end else begin
                            dis_d[c]   = 1'b1;
                            armed_d[c] = 1'b0;
                            pend_d[c]  = 1'b0;
                        end
                        state_d = IDLE;
                    end else if (preempt) begin
                        state_d = IDLE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        bus_req_d   = (state_d != IDLE);
        bus_wen_d   = (state_d == WRITE);
        bus_addr_d  = '0;
        bus_size_d  = 2'b00;
        bus_wdata_d = '0;
        if (state_d == READ)  bus_addr_d = sad_d[cur_d];
        if (state_d == WRITE) begin
            bus_addr_d  = dad_d[cur_d];
            bus_wdata_d = data_d;
        end
        if (state_d != IDLE) bus_size_d = word_d[cur_d] ? 2'b10 : 2'b01;
    end

    // State and output registers. The enable history is loaded from the live
    // enables during reset so a still-set enable does not re-arm on release.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            en_prev_q   <= ch_en;
            armed_q     <= '0;
            pend_q      <= '0;
            drop_q      <= '0;
            word_q      <= '0;
            sad_q       <= '0;
            dad_q       <= '0;
            cnt_q       <= '0;
            state_q     <= IDLE;
            cur_q       <= '0;
            data_q      <= '0;
            bus_req_q   <= 1'b0;
            bus_addr_q  <= '0;
            bus_wen_q   <= 1'b0;
            bus_size_q  <= 2'b00;
            bus_wdata_q <= '0;
            irq_q       <= '0;
            dis_q       <= '0;
        end else begin
            en_prev_q   <= en_prev_d;
            armed_q     <= armed_d;
            pend_q      <= pend_d;
            drop_q      <= drop_d;
            word_q      <= word_d;
            sad_q       <= sad_d;
            dad_q       <= dad_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            cur_q       <= cur_d;
            data_q      <= data_d;
            bus_req_q   <= bus_req_d;
            bus_addr_q  <= bus_addr_d;
            bus_wen_q   <= bus_wen_d;
            bus_size_q  <= bus_size_d;
            bus_wdata_q <= bus_wdata_d;
            irq_q       <= irq_d;
            dis_q       <= dis_d;
        end
    end

    assign bus.bus_req   = bus_req_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_wen   = bus_wen_q;
    assign bus.bus_size  = bus_size_q;
    assign bus.bus_wdata = bus_wdata_q;
    assign busy          = bus_req_q;
    assign irq           = irq_q;
    assign ch_disable    = dis_q;
endmodule

// File: tb/tb_dma_multi_channel.sv
// Directed bench for dma_multi_channel. Memory returns addr ^ 0xDEAD0000 on reads.
module tb_dma_multi_channel;
    localparam int NUM_CH = 4;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = 16;

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    logic [NUM_CH*ADDR_W-1:0] ch_sad = '0;
    logic [NUM_CH*ADDR_W-1:0] ch_dad = '0;
    logic [NUM_CH*CNT_W-1:0]  ch_cnt = '0;
    logic [NUM_CH*10-1:0]     ch_ctl = '0;
    logic [NUM_CH-1:0]        ch_trig = '0;
    logic                     busy;
    logic [NUM_CH-1:0]        irq, ch_disable;
    int ncmp = 0;
    int nerr = 0;
    int nbus;

    dma_multi_channel_if #(.ADDR_W(ADDR_W)) bif();
    assign bif.bus_rdata = bif.bus_addr ^ 32'hDEAD0000;

    always #5 clk = ~clk;

    dma_multi_channel #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_b(rst_b),
        .ch_sad(ch_sad), .ch_dad(ch_dad), .ch_cnt(ch_cnt),
        .ch_ctl(ch_ctl), .ch_trig(ch_trig),
        .bus(bif.master),
        .busy(busy), .irq(irq), .ch_disable(ch_disable)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bus(input string tag, input logic req, input logic wen,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [1:0] sz);
        chk({tag, ".req"}, bif.bus_req, req);
        chk({tag, ".busy"}, busy, req);
        if (req) begin
            chk({tag, ".wen"}, bif.bus_wen, wen);
            chk({tag, ".addr"}, bif.bus_addr, addr);
            chk({tag, ".size"}, bif.bus_size, sz);
            if (wen) chk({tag, ".wdata"}, bif.bus_wdata, wd);
        end
    endtask

    task automatic cfg(input int ch, input logic [31:0] sad, input logic [31:0] dad,
                       input logic [15:0] cnt, input logic [9:0] ctl);
        ch_sad[ch*ADDR_W +: ADDR_W] = sad;
        ch_dad[ch*ADDR_W +: ADDR_W] = dad;
        ch_cnt[ch*CNT_W +: CNT_W]   = cnt;
        ch_ctl[ch*10 +: 10]         = ctl;
    endtask

    task automatic set_en(input int ch, input logic v);
        ch_ctl[ch*10] = v;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a5 [3];
        bif.bus_ready = 1'b1;
        // Reset state
        tick(); tick();
        chk("rst.req", bif.bus_req, 1'b0);
        chk("rst.busy", busy, 1'b0);
        chk("rst.irq", irq, 4'h0);
        chk("rst.dis", ch_disable, 4'h0);
        rst_b = 1'b1;
        tick();

        // T1: ch0 word, 3 units, no waits, 2-cycle start latency
        cfg(0, 32'h100, 32'h200, 16'd3, 10'h009);
        tick();
        chk("t1.lat", bif.bus_req, 1'b0);
        tick();
        for (int u = 0; u < 3; u++) begin
            chk_bus("t1.rd", 1'b1, 1'b0, 32'h100 + 4*u, 32'h0, 2'b10);
            tick();
            chk_bus("t1.wr", 1'b1, 1'b1, 32'h200 + 4*u, 32'hDEAD0100 + 4*u, 2'b10);
            tick();
        end
        chk("t1.end.req", bif.bus_req, 1'b0);
        chk("t1.dis", ch_disable, 4'b0001);
        chk("t1.irq", irq, 4'h0);
        tick();
        chk("t1.dis_once", ch_disable, 4'h0);
        set_en(0, 1'b0);
        tick();

        // T2: same transfer with 2 wait cycles per transaction
        bif.bus_ready = 1'b0;
        cfg(0, 32'h100, 32'h200, 16'd3, 10'h009);
        tick(); tick();
        nbus = 0;
        for (int t = 0; t < 6; t++) begin
            for (int w = 0; w < 3; w++) begin
                if (t % 2 == 0)
                    chk_bus("t2.rd", 1'b1, 1'b0, 32'h100 + 4*(t/2), 32'h0, 2'b10);
                else
                    chk_bus("t2.wr", 1'b1, 1'b1, 32'h200 + 4*(t/2), 32'hDEAD0100 + 4*(t/2), 2'b10);
                if (bif.bus_req) nbus++;
                if (w == 2) bif.bus_ready = 1'b1;
                tick();
                bif.bus_ready = 1'b0;
            end
        end
        chk("t2.cycles", nbus, 18);
        chk("t2.end.req", bif.bus_req, 1'b0);
        chk("t2.dis", ch_disable, 4'b0001);
        bif.bus_ready = 1'b1;
        set_en(0, 1'b0);
        tick();

        // T3: ch3 halfword x8, ch1 triggered during ch3's second unit
        cfg(3, 32'h1000, 32'h2000, 16'd8, 10'h005);
        cfg(1, 32'h3000, 32'h4000, 16'd2, 10'h105);
        tick(); tick();
        chk_bus("t3.rd0", 1'b1, 1'b0, 32'h1000, 32'h0, 2'b01);
        tick();
        chk_bus("t3.wr0", 1'b1, 1'b1, 32'h2000, 32'hDEAD1000, 2'b01);
        tick();
        chk_bus("t3.rd1", 1'b1, 1'b0, 32'h1002, 32'h0, 2'b01);
        ch_trig = 4'b0010;
        tick();
        ch_trig = 4'b0000;
        chk_bus("t3.wr1", 1'b1, 1'b1, 32'h2002, 32'hDEAD1002, 2'b01);
        tick();
        chk("t3.preempt.req", bif.bus_req, 1'b0);
        tick();
        for (int u = 0; u < 2; u++) begin
            chk_bus("t3.c1rd", 1'b1, 1'b0, 32'h3000 + 2*u, 32'h0, 2'b01);
            tick();
            chk_bus("t3.c1wr", 1'b1, 1'b1, 32'h4000 + 2*u, 32'hDEAD3000 + 2*u, 2'b01);
            tick();
        end
        chk("t3.c1.req", bif.bus_req, 1'b0);
        chk("t3.irq1", irq, 4'b0010);
        chk("t3.dis1", ch_disable, 4'b0010);
        tick();
        for (int u = 2; u < 8; u++) begin
            chk_bus("t3.c3rd", 1'b1, 1'b0, 32'h1000 + 2*u, 32'h0, 2'b01);
            tick();
            chk_bus("t3.c3wr", 1'b1, 1'b1, 32'h2000 + 2*u, 32'hDEAD1000 + 2*u, 2'b01);
            tick();
        end
        chk("t3.c3.req", bif.bus_req, 1'b0);
        chk("t3.irq3", irq, 4'b1000);
        chk("t3.dis3", ch_disable, 4'b1000);
        set_en(1, 1'b0);
        set_en(3, 1'b0);
        tick();

        // T4: ch1 repeat, triggered, dst reload, 3 bursts of 2 words
        cfg(1, 32'h500, 32'h600, 16'd2, 10'h1CF);
        tick(); tick();
        chk("t4.wait_trig", bif.bus_req, 1'b0);
        for (int b = 0; b < 3; b++) begin
            ch_trig = 4'b0010;
            tick();
            ch_trig = 4'b0000;
            chk("t4.pend.req", bif.bus_req, 1'b0);
            tick();
            for (int u = 0; u < 2; u++) begin
                chk_bus("t4.rd", 1'b1, 1'b0, 32'h500 + 8*b + 4*u, 32'h0, 2'b10);
                tick();
                chk_bus("t4.wr", 1'b1, 1'b1, 32'h600 + 4*u, 32'hDEAD0500 + 8*b + 4*u, 2'b10);
                tick();
            end
            chk("t4.irq", irq, 4'b0010);
            chk("t4.nodis", ch_disable, 4'h0);
            chk("t4.idle", bif.bus_req, 1'b0);
            tick();
            chk("t4.rearm_idle", bif.bus_req, 1'b0);
        end
        set_en(1, 1'b0);
        tick();
        chk("t4.drop_nodis", ch_disable, 4'h0);

        // T5: decrementing halfword source wraps below zero
        a5[0] = 32'h0000_0002; a5[1] = 32'h0000_0000; a5[2] = 32'hFFFF_FFFE;
        cfg(2, 32'h2, 32'h700, 16'd3, 10'h011);
        tick(); tick();
        for (int u = 0; u < 3; u++) begin
            chk_bus("t5.rd", 1'b1, 1'b0, a5[u], 32'h0, 2'b01);
            tick();
            chk_bus("t5.wr", 1'b1, 1'b1, 32'h700 + 2*u, a5[u] ^ 32'hDEAD0000, 2'b01);
            tick();
        end
        chk("t5.dis", ch_disable, 4'b0100);
        set_en(2, 1'b0);
        tick();

        // T6: reset asserted during WRITE
        cfg(0, 32'h100, 32'h200, 16'd3, 10'h00D);
        tick(); tick();
        chk_bus("t6.rd", 1'b1, 1'b0, 32'h100, 32'h0, 2'b10);
        tick();
        chk_bus("t6.wr", 1'b1, 1'b1, 32'h200, 32'hDEAD0100, 2'b10);
        rst_b = 1'b0;
        tick();
        chk("t6.req", bif.bus_req, 1'b0);
        chk("t6.busy", busy, 1'b0);
        chk("t6.irq", irq, 4'h0);
        chk("t6.dis", ch_disable, 4'h0);
        rst_b = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t6.quiet", bif.bus_req, 1'b0);
        end
        set_en(0, 1'b0);
        tick();
        set_en(0, 1'b1);
        tick(); tick();
        chk_bus("t6.rerun", 1'b1, 1'b0, 32'h100, 32'h0, 2'b10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule

// File: doc/dma_multi_channel.md
Name: dma_multi_channel

Overview:
Parametrised multi-channel DMA engine, successor to the fixed four-channel GBA DMA unit. It arbitrates NUM_CH channels by fixed priority (channel 0 highest) and preempts only at unit boundaries. Transfers move over a single valid/ready memory bus port, with no tri-state bus. It sits between the MMIO register file, which supplies per-channel configuration and receives enable-clear pulses, and the memory arbiter. It reports per-channel IRQs to the interrupt controller.

Parameters:
NUM_CH, 4, number of channels; index 0 has the highest priority
ADDR_W, 32, address width
CNT_W, 16, transfer-count width; a count of 0 means 2^CNT_W units

Ports:
clk  input  1  system clock
rst_b  input  1  synchronous active-low reset
ch_sad  input  NUM_CH*ADDR_W  source address per channel; channel i occupies slice [i*ADDR_W +: ADDR_W]
ch_dad  input  NUM_CH*ADDR_W  destination address per channel
ch_cnt  input  NUM_CH*CNT_W  unit count per channel
ch_ctl  input  NUM_CH*10  per channel: [0] enable, [1] repeat, [2] irq_en, [3] word (1=32b, 0=16b), [5:4] src_mode, [7:6] dst_mode, [9:8] start_mode
ch_trig  input  NUM_CH  start-event strobe per channel (hblank, vblank, sound FIFO)
bus_req  output  1  transaction request
bus_addr  output  ADDR_W  transaction address
bus_wen  output  1  1=write, 0=read
bus_size  output  2  2'b10 word, 2'b01 halfword
bus_wdata  output  32  write data
bus_rdata  input  32  read data, valid while bus_req&bus_ready&~bus_wen
bus_ready  input  1  completes the current transaction
busy  output  1  engine owns the bus (state READ or WRITE)
irq  output  NUM_CH  one-cycle completion pulse per channel
ch_disable  output  NUM_CH  one-cycle pulse telling MMIO to clear the enable bit

Behaviour:
- Reset (rst_b low at a posedge), including mid-transfer: every output is 0 the next cycle; all shadow state, pending flags and counters are cleared; the FSM enters IDLE.
- Arming: a rising edge of ch_ctl[0] (the previous value is registered) latches shadow sad, dad and cnt; the channel becomes armed. Alignment is enforced on the latched addresses: word mode clears addr[1:0]; halfword mode clears addr[0].
- Pending (armed channels only):
  - start_mode 0: pending the cycle after arming.
  - start_mode 1, 2 or 3: pending on ch_trig[i]=1.
  - A trigger on a channel that is already pending or active is dropped; at most one request is held.
- FSM states: IDLE, READ, WRITE.
  - IDLE: if any channel is pending, grant the lowest pending index and go to READ the next cycle.
  - READ: bus_req=1, wen=0, addr=src. On bus_ready, capture bus_rdata and go to WRITE.
  - WRITE: bus_req=1, wen=1, addr=dst, wdata=captured data. On bus_ready: step src/dst, decrement remaining count, then handle unit completion.
- Unit completion:
  - If the remaining count reaches 0, the channel is done.
  - Otherwise re-arbitrate in the same cycle. If a lower-index channel is pending, go to IDLE, where that channel is granted. The preempted channel keeps its shadow state and stays pending.
  - Otherwise go directly to READ for the same channel. Back-to-back units therefore have no bubble.
- Bus outputs hold stable while bus_req=1 and bus_ready=0. Wait states are unbounded.
- Stepping, with step = 4 (word) or 2 (halfword):
  - mode 0 or 3: increment by step.
  - mode 1: decrement by step.
  - mode 2: fixed.
  - src_mode 3 behaves as mode 0.
  - Addresses wrap modulo 2^ADDR_W.
- Done:
  - irq[i] pulses if irq_en is set.
  - With repeat=1 and start_mode≠0: reload cnt from ch_cnt; reload dad from ch_dad only if dst_mode=3; the channel stays armed and non-pending.
  - Otherwise ch_disable[i] pulses and the channel disarms.
  - The FSM returns to IDLE.
- Enable dropped while a channel is active: the current READ+WRITE unit completes, then the channel disarms without an irq or ch_disable pulse. Enable dropped while only pending: the channel disarms immediately.
- Config writes to ch_sad, ch_dad or ch_cnt while armed are ignored until the next enable rising edge.
- Latency: with bus_ready tied high, arming (start_mode 0) to the first bus_req is 2 cycles. Each unit takes 2 cycles.

Test Plan:
- Ch0 word, sad=0x100, dad=0x200, cnt=3, modes 0/0, ready=1 -> reads 0x100/0x104/0x108 interleaved with writes 0x200/0x204/0x208 in 6 consecutive cycles; ch_disable[0] pulses; no irq.
- Same transfer with 2 wait cycles per transaction -> addr, wdata and size stay stable while waiting; data is written correctly; total 18 bus cycles.
- Ch3 immediate start, cnt=8 halfword; ch1 triggered during the second unit -> ch3 finishes unit 2, ch1 runs to completion, ch3 resumes with dst=base+4; irq[1] pulses before irq[3].
- Ch1 repeat, start_mode 1, dst_mode 3, cnt=2, three triggers -> each burst writes the reloaded dad, dad+4; no ch_disable; irq pulses 3 times with irq_en=1.
- Decrement src (src_mode 1) with sad=0x2 halfword -> addresses 0x2, 0x0, then wrap to 0xFFFF_FFFE.
- rst_b low during WRITE -> next cycle bus_req, busy and irq are 0; after release nothing runs until enable is re-asserted.
